seven_segment_scan_controller: RTL and testbench

//   Sequences the 4-digit seven-segment display datapath: generates the digit scan
//   (digitSelect feeding the nibble mux / enable decoder), per-digit PWM brightness

---
 rtl/seven_segment_scan_controller.sv | 99 +++++++++
 tb/tb_seven_segment_scan_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Scan sequencer for a 4-digit seven-segment display: digit scan, per-digit PWM
// brightness with inter-digit blanking, and a frame-atomic valid/ready value update.
module seven_segment_scan_controller #(
    parameter int TICKS_PER_DIGIT = 1000,
    parameter int BLANK_TICKS     = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        updateValid,
    output logic        updateReady,
    input  logic [15:0] updateValue,
    input  logic [3:0]  brightness,
    input  logic        displayEnable,
    output logic [1:0]  digitSelect,
    output logic [15:0] activeValue,
    output logic [3:0]  segmentEnable,
    output logic        frameStart
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } update_state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_TICK   = COUNT_WIDTH'(TICKS_PER_DIGIT - 1);
    localparam logic [COUNT_WIDTH-1:0] BLANK_START = COUNT_WIDTH'(BLANK_TICKS);

    update_state_t          state;
    update_state_t          state_next;
    logic [COUNT_WIDTH-1:0] tick_count;
    logic [15:0]            shadow;
    logic [3:0]             bright_latched;
    logic                   last_tick;
    logic                   frame_boundary;
    logic                   lit;

    assign last_tick      = (tick_count == LAST_TICK);
    assign frame_boundary = last_tick && (digitSelect == 2'd3);
    assign lit            = displayEnable && (tick_count >= BLANK_START)
                            && (tick_count[3:0] <= bright_latched);
    assign updateReady    = (state == IDLE);
    assign frameStart     = (tick_count == '0) && (digitSelect == 2'd0);

    // NOTE: state_next gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (updateValid) state_next = HELD;
            HELD: if (frame_boundary) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples the pre-edge values (commit sees pending before a same-edge accept).
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_count  <= '0;
            digitSelect <= 2'd0;
        end else if (last_tick) begin
            tick_count  <= '0;
            digitSelect <= digitSelect + 2'd1;
        end else begin
            tick_count  <= tick_count + 1'b1;
        end
    end

    // Shadow captures on accept; the displayed value and brightness only move at
    // the frame boundary so a frame is never drawn with mixed digits or duty.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow         <= '0;
            activeValue    <= '0;
            bright_latched <= 4'd15;
            segmentEnable  <= 4'b1111;
        end else begin
            if (state == IDLE && updateValid) begin
                shadow <= updateValue;
            end
            if (state == HELD && frame_boundary) begin
                activeValue <= shadow;
            end
            if (frame_boundary) begin
                bright_latched <= brightness;
            end
            segmentEnable <= lit ? ~(4'b0001 << digitSelect) : 4'b1111;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: the driver advances a frame-arithmetic reference model and queues
// the expected outputs; an independent monitor compares them after every clock edge.
module tb_seven_segment_scan_controller;

    localparam int T     = 40;
    localparam int B     = 4;
    localparam int FRAME = 4 * T;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        updateValid = 1'b0;
    logic        updateReady;
    logic [15:0] updateValue = '0;
    logic [3:0]  brightness = 4'd15;
    logic        displayEnable = 1'b1;
    logic [1:0]  digitSelect;
    logic [15:0] activeValue;
    logic [3:0]  segmentEnable;
    logic        frameStart;

    seven_segment_scan_controller #(
        .TICKS_PER_DIGIT(T),
        .BLANK_TICKS(B),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .updateValid(updateValid),
        .updateReady(updateReady),
        .updateValue(updateValue),
        .brightness(brightness),
        .displayEnable(displayEnable),
        .digitSelect(digitSelect),
        .activeValue(activeValue),
        .segmentEnable(segmentEnable),
        .frameStart(frameStart)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  digit;
        logic [15:0] active;
        logic        ready;
        logic [3:0]  seg;
        logic        frame_start;
    } obs_t;

    obs_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   cycle_no      = 0;

    // Reference model: scan position is pure arithmetic on cycles since reset.
    int          n = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    int          m_bright = 15;
    logic [3:0]  m_seg = 4'hF;

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks_total++;
        if (got === want) begin
            checks_passed++;
        end else begin
            $display("FAIL %s @%0d: got digit=%0d active=%h ready=%b seg=%b fs=%b, expected digit=%0d active=%h ready=%b seg=%b fs=%b",
                     name, cycle_no, got.digit, got.active, got.ready, got.seg, got.frame_start,
                     want.digit, want.active, want.ready, want.seg, want.frame_start);
        end
    endtask

    task automatic step(input bit rst, input bit valid, input logic [15:0] value,
                        input logic [3:0] bright, input bit en);
        int   tick;
        int   digit;
        bit   fb;
        bit   lit;
        bit   was_pending;
        obs_t e;
        @(negedge clock);
        reset         = rst;
        updateValid   = valid;
        updateValue   = value;
        brightness    = bright;
        displayEnable = en;
        if (rst) begin
            n = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_bright = 15; m_seg = 4'hF;
        end else begin
            tick  = n % T;
            digit = (n / T) % 4;
            fb    = (n % FRAME) == FRAME - 1;
            lit   = en && (tick >= B) && ((tick % 16) <= m_bright);
            m_seg = 4'hF;
            if (lit) m_seg[digit] = 1'b0;
            was_pending = m_pending;
            if (was_pending && fb) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (!was_pending && valid) begin
                m_shadow  = value;
                m_pending = 1'b1;
            end
            if (fb) m_bright = int'(bright);
            n++;
        end
        e.digit       = 2'((n / T) % 4);
        e.active      = m_active;
        e.ready       = !m_pending;
        e.seg         = m_seg;
        e.frame_start = (n % FRAME) == 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles, input logic [3:0] bright, input bit en);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, bright, en);
    endtask

    task automatic idle_until(input int frame_pos, input logic [3:0] bright);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != frame_pos; i++)
            step(1'b0, 1'b0, 16'h0, bright, 1'b1);
    endtask

    obs_t mon_want;
    obs_t mon_got;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                mon_want = exp_q.pop_front();
                mon_got  = {digitSelect, activeValue, updateReady, segmentEnable, frameStart};
                check("cycle", mon_got, mon_want);
            end
        end
    end

    initial begin
        // Reset, then free-running scan at full brightness.
        step(1'b1, 1'b0, 16'h0, 4'd15, 1'b1);
        step(1'b1, 1'b1, 16'hFFFF, 4'd15, 1'b1);
        idle(200, 4'd15, 1'b1);

        // Mid-frame update appears only after the frame boundary.
        idle_until(50, 4'd15);
        step(1'b0, 1'b1, 16'h1234, 4'd15, 1'b1);
        idle(FRAME + 20, 4'd15, 1'b1);

        // Accept on the boundary cycle waits a whole frame; a valid while held is dropped.
        idle_until(FRAME - 1, 4'd15);
        step(1'b0, 1'b1, 16'hBEEF, 4'd15, 1'b1);
        step(1'b0, 1'b1, 16'h0001, 4'd15, 1'b1);
        idle(2 * FRAME + 10, 4'd15, 1'b1);

        // Minimum brightness, then a mid-frame change that only lands at the next boundary.
        idle_until(20, 4'd0);
        idle(FRAME + 60, 4'd0, 1'b1);
        idle(2 * FRAME, 4'd7, 1'b1);

        // Display disabled for 100 cycles, then re-enabled.
        idle(100, 4'd15, 1'b0);
        idle(60, 4'd15, 1'b1);

        // Reset while an update is held during digit 2.
        idle_until(10, 4'd15);
        step(1'b0, 1'b1, 16'hCAFE, 4'd15, 1'b1);
        idle_until(2 * T + 10, 4'd15);
        step(1'b1, 1'b0, 16'h0, 4'd15, 1'b1);
        idle(FRAME + 10, 4'd15, 1'b1);

        // Randomized traffic.
        begin
            logic [3:0] br;
            br = 4'd15;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 99) == 0) br = 4'($urandom_range(0, 15));
                step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0,
                     16'($urandom), br, $urandom_range(0, 19) != 0);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        checks_total++;
        if (exp_q.size() == 0) begin
            checks_passed++;
        end else begin
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
